// File: rtl/subtractor_serial_8.sv
// Bit-serial subtractor: D = A - B, one full-subtractor step per clock, LSB first.
// D is {borrow, difference} and only changes on the transition into DONE.
module subtractor_serial_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   D
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [CW-1:0]    cnt;
  logic             bor;
  logic             load;
  logic             last;
  logic             d_bit;
  logic             bor_nxt;

  // Returns {borrow_out, difference} of a single-bit a - b - bin.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  always_comb begin
    {bor_nxt, d_bit} = full_sub(a_reg[0], b_reg[0], bor);
    last             = (cnt == LAST);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they carry no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt     <= '0;
      bor     <= 1'b0;
      D       <= '0;
    end else if (load) begin
      a_reg <= A;
      b_reg <= B;
      bor   <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      bor     <= bor_nxt;
      res_reg <= {d_bit, res_reg[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
      // The final bit is merged directly so D never exposes a partial result.
      if (last) D <= {bor_nxt, d_bit, res_reg[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_subtractor_serial_8.sv
// Directed and randomized checks of subtractor_serial_8 against an arithmetic reference.
module tb_subtractor_serial_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       busy, done;
  logic [8:0] D;

  int n_pass  = 0;
  int n_total = 0;
  logic [8:0] exp_prev;

  subtractor_serial_8 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .D    (D)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
    int diff;
    diff = int'(a) - int'(b);
    return 9'(diff);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Waits (bounded) for done; drops start after the first cycle unless keep is set.
  task automatic wait_done(input bit keep, output int cyc, output int nbusy);
    bit seen;
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (!keep) start = 1'b0;
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      check("d_hold", 32'(D), 32'(exp_prev));
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    check(tag, 32'(D), 32'(ref_sub(a, b)));
    s = {1'b0, D[7:0]} + {1'b0, b};
    check("adder_roundtrip", 32'(s), 32'({D[8], a}));
    exp_prev = ref_sub(a, b);
  endtask

  logic [7:0] bnd_a [4] = '{8'h00, 8'hFF, 8'hAA, 8'h00};
  logic [7:0] bnd_b [4] = '{8'hFF, 8'h00, 8'hAA, 8'h01};
  logic [8:0] bnd_d [4] = '{9'h101, 9'h0FF, 9'h000, 9'h1FF};

  initial begin
    int cyc, nbusy, gap;
    bit keep, seen;
    logic [7:0] ra, rb;

    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    exp_prev = '0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(D), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({busy, done, D}), 32'd0);
    end

    // Basic operation with latency and busy-length checks.
    launch(8'd200, 8'd55);
    wait_done(1'b0, cyc, nbusy);
    check("basic_latency", 32'(cyc), 32'd9);
    check("basic_busy_cycles", 32'(nbusy), 32'd8);
    check("basic_d", 32'(D), 32'h091);
    check_result("basic_ref", 8'd200, 8'd55);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("d_held_idle", 32'(D), 32'h091);

    // Boundary operands.
    for (int k = 0; k < 4; k++) begin
      launch(bnd_a[k], bnd_b[k]);
      wait_done(1'b0, cyc, nbusy);
      check("boundary_d", 32'(D), 32'(bnd_d[k]));
      check_result("boundary_ref", bnd_a[k], bnd_b[k]);
      @(negedge clk);
    end

    // Operand changes and start pulses during SHIFT are ignored.
    launch(8'd200, 8'd55);
    @(negedge clk);
    A = 8'h00; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, cyc, nbusy);
    check("ignore_latency", 32'(cyc), 32'd7);
    check_result("ignore_d", 8'd200, 8'd55);
    @(negedge clk);

    // start held high: back-to-back results every 9 cycles.
    launch(8'd10, 8'd20);
    for (int k = 0; k < 5; k++) begin
      wait_done(1'b1, cyc, nbusy);
      check("stream_period", 32'(cyc), 32'd9);
      check_result("stream_d", A, B);
      A = A + 8'd37;
      B = B ^ 8'h5C;
    end
    start = 1'b0;
    @(negedge clk);

    // Abort mid-operation via asynchronous reset.
    launch(8'd99, 8'd33);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_d", 32'(D), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_prev = '0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    launch(8'd99, 8'd33);
    wait_done(1'b0, cyc, nbusy);
    check("after_abort_latency", 32'(cyc), 32'd9);
    check_result("after_abort_d", 8'd99, 8'd33);

    // Randomized operations with idle gaps and starts in the DONE cycle.
    for (int k = 0; k < 3000; k++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      keep = 1'($urandom_range(0, 1));
      launch(ra, rb);
      wait_done(keep, cyc, nbusy);
      check("rand_latency", 32'(cyc), 32'd9);
      check_result("rand_d", ra, rb);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        start = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
